muldiv_iter: RTL and testbench



---
 rtl/muldiv_iter.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_iter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shared shift-add / restoring-subtract engine, WIDTH+1 cycle latency.
// Optional build macro MULDIV_EARLY_OUT_EN lets multiplies finish once the remaining multiplier bits are zero.
module muldiv_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             dbz
);

   localparam logic [1:0] OP_MULT = 2'b00;
   localparam logic [1:0] OP_DIV  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIN
   } state_t;

   state_t r_state;
   state_t w_next;

   logic               r_is_div;
   logic               r_sign_a;
   logic               r_sign_b;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;     // product, or {remainder, quotient/dividend}
   logic [2*WIDTH-1:0] r_mcand;   // shifting multiplicand; low half keeps |a| for divides
   logic [WIDTH-1:0]   r_b;       // shifting multiplier, or fixed divisor
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_dbz;

   logic               w_signed;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic               w_launch;
   logic               w_last;
   logic [WIDTH:0]     w_shift;
   logic               w_ge;
   logic [WIDTH-1:0]   w_diff;
   logic               w_neg_res;
   logic               w_div_zero;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_a_back;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;
   logic               w_res_dbz;

   // Operand capture: magnitudes are stored unsigned, so the most-negative value needs no special case.
   assign w_signed = (op == OP_MULT) || (op == OP_DIV);
   assign w_a_neg  = w_signed & a[WIDTH-1];
   assign w_b_neg  = w_signed & b[WIDTH-1];
   assign w_a_mag  = w_a_neg ? -a : a;
   assign w_b_mag  = w_b_neg ? -b : b;
   assign w_launch = (r_state == S_IDLE) && start && !cancel;

`ifdef MULDIV_EARLY_OUT_EN
   assign w_last = (r_cnt == CNT_W'(WIDTH-1)) || (!r_is_div && (r_b[WIDTH-1:1] == '0));
`else
   assign w_last = (r_cnt == CNT_W'(WIDTH-1));
`endif

   // Restoring step; when w_ge holds the true difference is below the divisor, so W bits suffice.
   assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_ge    = w_shift >= {1'b0, r_b};
   assign w_diff  = w_shift[WIDTH-1:0] - r_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_launch) w_next = S_CALC;
         end
         S_CALC: begin
            if (cancel)      w_next = S_IDLE;
            else if (w_last) w_next = S_FIN;
         end
         S_FIN: begin
            w_next = S_IDLE;
            done   = !cancel;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign busy = (r_state != S_IDLE);

   // Sign correction of the raw engine result, applied in the FIN cycle.
   assign w_neg_res  = r_sign_a ^ r_sign_b;
   assign w_div_zero = (r_b == '0);
   assign w_prod     = w_neg_res ? -r_acc : r_acc;
   assign w_quo      = w_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem      = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
   assign w_a_back   = r_sign_a ? -r_mcand[WIDTH-1:0] : r_mcand[WIDTH-1:0];

   always_comb begin
      w_res_hi  = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo  = w_prod[WIDTH-1:0];
      w_res_dbz = 1'b0;
      if (r_is_div) begin
         if (w_div_zero) begin
            w_res_hi  = w_a_back;
            w_res_lo  = '1;
            w_res_dbz = 1'b1;
         end else begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
         end
      end
   end

   // NOTE: results show combinationally during the done cycle and are captured for holding afterwards.
   assign hi_o = done ? w_res_hi  : r_hi;
   assign lo_o = done ? w_res_lo  : r_lo;
   assign dbz  = done ? w_res_dbz : r_dbz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_is_div <= 1'b0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_b      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_dbz    <= 1'b0;
      end else begin
         if (w_launch) begin
            r_is_div <= op[1];
            r_sign_a <= w_a_neg;
            r_sign_b <= w_b_neg;
            r_cnt    <= '0;
            r_acc    <= op[1] ? {{WIDTH{1'b0}}, w_a_mag} : '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_b      <= w_b_mag;
         end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_is_div) begin
               r_acc <= {(w_ge ? w_diff : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
            end else begin
               r_acc   <= r_acc + (r_b[0] ? r_mcand : '0);
               r_mcand <= r_mcand << 1;
               r_b     <= r_b >> 1;
            end
         end
         if (done) begin
            r_hi  <= w_res_hi;
            r_lo  <= w_res_lo;
            r_dbz <= w_res_dbz;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: reference model feeds a scoreboard queue, popped on each done pulse.
// Expected multiply latency follows MULDIV_EARLY_OUT_EN when the bench is built with it.
module tb_muldiv_iter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cancel;
   logic         busy;
   logic         done;
   logic [W-1:0] hi_o;
   logic [W-1:0] lo_o;
   logic         dbz;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } res_t;

   res_t sb[$];
   res_t held;
   int   total = 0;
   int   bad   = 0;

   muldiv_iter #(.WIDTH(W), .CNT_W(6)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .cancel (cancel),
      .busy   (busy),
      .done   (done),
      .hi_o   (hi_o),
      .lo_o   (lo_o),
      .dbz    (dbz)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic res_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      res_t        r;
      longint      sx;
      longint      sy;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = '0;
      case (o)
         2'b00: begin p = sx * sy; r.hi = p[63:32]; r.lo = p[31:0]; end
         2'b01: begin p = {32'h0, x} * {32'h0, y}; r.hi = p[63:32]; r.lo = p[31:0]; end
         default: begin
            if (y == '0) begin
               r.dbz = 1'b1; r.lo = '1; r.hi = x;
            end else if (o == 2'b10) begin
               p = sx / sy; r.lo = p[31:0];
               p = sx % sy; r.hi = p[31:0];
            end else begin
               r.lo = x / y; r.hi = x % y;
            end
         end
      endcase
      return r;
   endfunction

   function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] y);
      int lat = W + 1;
`ifdef MULDIV_EARLY_OUT_EN
      logic [W-1:0] m;
      if (!o[1]) begin
         m   = (o == 2'b00 && y[W-1]) ? -y : y;
         lat = 2;
         for (int i = 1; i < W; i++) if (m[i]) lat = i + 2;
      end
`endif
      return lat;
   endfunction

   // Launch one operation, scramble the inputs while it runs, and compare on done.
   task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string tag, input bit poke_start);
      res_t e;
      int   lat;
      int   want_lat;
      int   busy_cnt;
      bit   seen;
      e        = model(o, x, y);
      want_lat = exp_lat(o, y);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      seen = 1'b0; lat = 0; busy_cnt = 0;
      for (int c = 1; c <= W + 5 && !seen; c++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            seen = 1'b1;
            lat  = c;
            e    = sb.pop_front();
            check({tag, "_hi"},  hi_o, e.hi);
            check({tag, "_lo"},  lo_o, e.lo);
            check({tag, "_dbz"}, dbz,  e.dbz);
            held = e;
         end
         start = poke_start && (c == 3);
         op    = 2'($urandom);
         a     = $urandom;
         b     = $urandom;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, seen, 1);
      if (!seen) void'(sb.pop_front());
      check({tag, "_latency"},  lat,      want_lat);
      check({tag, "_busy_cyc"}, busy_cnt, want_lat);
      @(negedge clk);
      check({tag, "_idle_after"}, busy, 0);
      check({tag, "_hold_hi"},    hi_o, held.hi);
      check({tag, "_hold_lo"},    lo_o, held.lo);
   endtask

   int dones;

   initial begin
      rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
      held = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hi",   hi_o, 0);
      check("rst_lo",   lo_o, 0);
      check("rst_dbz",  dbz,  0);
      rst = 1'b0;

      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0);
      do_op(2'b00, 32'hFFFF_FFF9, 32'd3,         "mult_neg",  1'b0);
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2,         "div_neg",   1'b0);
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf",   1'b0);
      do_op(2'b11, 32'd100,       32'd0,         "divu_zero", 1'b0);
      do_op(2'b10, 32'h8000_0000, 32'd0,         "div_zero",  1'b0);
      do_op(2'b01, 32'h1234_5678, 32'd1,         "multu_one", 1'b0);
      do_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minmin", 1'b1);

      for (int i = 0; i < 8; i++)
         do_op(2'(i), $urandom, (i > 3) ? $urandom_range(1, 300) : $urandom, "rand", 1'b0);

      // Cancel mid-divide: no done, outputs keep the last committed result.
      @(negedge clk);
      start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
      dones = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) dones++;
         if (c == 10) cancel = 1'b1;
      end
      @(negedge clk);
      cancel = 1'b0;
      check("cancel_busy",  busy,  0);
      check("cancel_done",  dones, 0);
      check("cancel_hi",    hi_o,  held.hi);
      check("cancel_lo",    lo_o,  held.lo);
      do_op(2'b11, 32'd100, 32'd7, "divu_after_cancel", 1'b0);

      // start together with cancel is dropped.
      @(negedge clk);
      start = 1'b1; cancel = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      check("start_cancel_busy", busy, 0);
      @(negedge clk);
      check("start_cancel_idle", busy, 0);

      // Asynchronous reset in the middle of a multiply.
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd1234; b = 32'd77;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_hi",   hi_o, 0);
      check("arst_lo",   lo_o, 0);
      check("arst_dbz",  dbz,  0);
      @(negedge clk);
      rst  = 1'b0;
      held = '0;
      dones = 0;
      for (int c = 0; c < W + 5; c++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("arst_no_done", dones, 0);
      check("arst_hold_hi", hi_o, 0);

      do_op(2'b10, 32'd1000, 32'hFFFF_FFFD, "div_after_rst", 1'b0);

      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
